// File: rtl/rs_array_if.sv
// Bus bundle for the reservation-station array.
// Groups the squash, dispatch, CDB, issue and occupancy signals.
// The master side drives dispatch/CDB/FU-ready; the slave side is the RS array.
interface rs_array_if #(
  parameter int RS_DEPTH = 8,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32
);
  logic                        squash;
  logic                        disp_valid;
  logic [TAG_W-1:0]            disp_dest_tag;
  logic [TAG_W-1:0]            disp_rs1_tag;
  logic [TAG_W-1:0]            disp_rs2_tag;
  logic                        disp_rs1_ready;
  logic                        disp_rs2_ready;
  logic [DATA_W-1:0]           disp_rf_rs1;
  logic [DATA_W-1:0]           disp_rf_rs2;
  logic [DATA_W-1:0]           disp_rob_rs1;
  logic [DATA_W-1:0]           disp_rob_rs2;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [DATA_W-1:0]           cdb_value;
  logic                        fu_ready;
  logic                        issue_valid;
  logic [TAG_W-1:0]            issue_dest_tag;
  logic [DATA_W-1:0]           issue_rs1;
  logic [DATA_W-1:0]           issue_rs2;
  logic                        full;
  logic [$clog2(RS_DEPTH):0]   free_count;

  modport master (
    output squash, disp_valid, disp_dest_tag, disp_rs1_tag, disp_rs2_tag,
           disp_rs1_ready, disp_rs2_ready, disp_rf_rs1, disp_rf_rs2,
           disp_rob_rs1, disp_rob_rs2, cdb_valid, cdb_tag, cdb_value, fu_ready,
    input  issue_valid, issue_dest_tag, issue_rs1, issue_rs2, full, free_count
  );

  modport slave (
    input  squash, disp_valid, disp_dest_tag, disp_rs1_tag, disp_rs2_tag,
           disp_rs1_ready, disp_rs2_ready, disp_rf_rs1, disp_rf_rs2,
           disp_rob_rs1, disp_rob_rs2, cdb_valid, cdb_tag, cdb_value, fu_ready,
    output issue_valid, issue_dest_tag, issue_rs1, issue_rs2, full, free_count
  );
endinterface

// File: rtl/rs_array.sv
// Reservation-station array: dispatch with operand resolution and CDB bypass,
// CDB wakeup, saturating per-entry ages and single-issue selection.
// Build option: define RS_OLDEST_FIRST_EN to issue the oldest ready entry
// (largest age, ties to lowest index); otherwise the lowest-index ready entry.
module rs_array #(
  parameter int RS_DEPTH = 8,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int AGE_W    = 4
) (
  input logic        clock,
  input logic        reset,
  rs_array_if.slave  bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [RS_DEPTH-1:0] busy, rdy1, rdy2, ready;
  logic [TAG_W-1:0]    tag1 [RS_DEPTH];
  logic [TAG_W-1:0]    tag2 [RS_DEPTH];
  logic [TAG_W-1:0]    dest [RS_DEPTH];
  logic [DATA_W-1:0]   val1 [RS_DEPTH];
  logic [DATA_W-1:0]   val2 [RS_DEPTH];
  logic [AGE_W-1:0]    age  [RS_DEPTH];
  // Entry presented last cycle while the FU stalled; keeps issue outputs stable.
  logic                hold_vld;
  logic [IDX_W-1:0]    hold_idx;

  logic [CNT_W-1:0]    busy_cnt;
  logic                alloc_found;
  logic [IDX_W-1:0]    alloc_idx;
  logic                any_rdy;
  logic [IDX_W-1:0]    best_idx, sel_idx;
  logic                fire, disp_go;
  logic                d_rdy1, d_rdy2;
  logic [DATA_W-1:0]   d_val1, d_val2;

  function automatic logic cdb_hit(input logic cv, input logic [TAG_W-1:0] ct,
                                   input logic [TAG_W-1:0] tag);
    return cv && (ct != '0) && (ct == tag);
  endfunction

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + AGE_W'(1);
  endfunction

  // Returns {ready, value} for a dispatching operand: RF, ROB, same-cycle CDB, or wait.
  function automatic logic [DATA_W:0] resolve(
    input logic [TAG_W-1:0] tag, input logic rob_rdy,
    input logic [DATA_W-1:0] rf, input logic [DATA_W-1:0] rob,
    input logic cv, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cval);
    if (tag == '0)              return {1'b1, rf};
    if (rob_rdy)                return {1'b1, rob};
    if (cdb_hit(cv, ct, tag))   return {1'b1, cval};
    return {1'b0, {DATA_W{1'b0}}};
  endfunction

  assign ready = busy & rdy1 & rdy2;

  // Occupancy and lowest-index free slot, from registered busy bits only.
  always_comb begin
    busy_cnt    = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy_cnt = busy_cnt + CNT_W'(busy[i]);
      if (!busy[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  // Issue selection; a stalled choice is held unless a strictly older entry is ready.
  always_comb begin
    any_rdy  = 1'b0;
    best_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready[i]) begin
`ifdef RS_OLDEST_FIRST_EN
        if (!any_rdy || (age[i] > age[best_idx])) best_idx = IDX_W'(i);
`else
        if (!any_rdy) best_idx = IDX_W'(i);
`endif
        any_rdy = 1'b1;
      end
    end
    sel_idx = best_idx;
`ifdef RS_OLDEST_FIRST_EN
    if (hold_vld && ready[hold_idx] && (age[hold_idx] >= age[best_idx])) sel_idx = hold_idx;
`else
    if (hold_vld && ready[hold_idx]) sel_idx = hold_idx;
`endif
  end

  assign {d_rdy1, d_val1} = resolve(bus.disp_rs1_tag, bus.disp_rs1_ready, bus.disp_rf_rs1,
                                    bus.disp_rob_rs1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
  assign {d_rdy2, d_val2} = resolve(bus.disp_rs2_tag, bus.disp_rs2_ready, bus.disp_rf_rs2,
                                    bus.disp_rob_rs2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

  assign fire    = any_rdy && bus.fu_ready;
  assign disp_go = bus.disp_valid && alloc_found;

  assign bus.issue_valid    = any_rdy;
  assign bus.issue_dest_tag = any_rdy ? dest[sel_idx] : '0;
  assign bus.issue_rs1      = any_rdy ? val1[sel_idx] : '0;
  assign bus.issue_rs2      = any_rdy ? val2[sel_idx] : '0;
  assign bus.full           = &busy;
  assign bus.free_count     = CNT_W'(RS_DEPTH) - busy_cnt;

  // Entry state: squash beats issue/dispatch; otherwise age, wake, free, allocate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      rdy1     <= '0;
      rdy2     <= '0;
      hold_vld <= 1'b0;
      hold_idx <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        tag1[i] <= '0;
        tag2[i] <= '0;
        dest[i] <= '0;
        val1[i] <= '0;
        val2[i] <= '0;
        age[i]  <= '0;
      end
    end else if (bus.squash) begin
      busy     <= '0;
      hold_vld <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy[i]) begin
          age[i] <= age_sat_inc(age[i]);
          if (!rdy1[i] && cdb_hit(bus.cdb_valid, bus.cdb_tag, tag1[i])) begin
            rdy1[i] <= 1'b1;
            val1[i] <= bus.cdb_value;
          end
          if (!rdy2[i] && cdb_hit(bus.cdb_valid, bus.cdb_tag, tag2[i])) begin
            rdy2[i] <= 1'b1;
            val2[i] <= bus.cdb_value;
          end
        end
      end
      if (fire) busy[sel_idx] <= 1'b0;
      if (disp_go) begin
        busy[alloc_idx] <= 1'b1;
        age[alloc_idx]  <= '0;
        dest[alloc_idx] <= bus.disp_dest_tag;
        tag1[alloc_idx] <= bus.disp_rs1_tag;
        tag2[alloc_idx] <= bus.disp_rs2_tag;
        rdy1[alloc_idx] <= d_rdy1;
        rdy2[alloc_idx] <= d_rdy2;
        val1[alloc_idx] <= d_val1;
        val2[alloc_idx] <= d_val2;
      end
      hold_vld <= any_rdy && !bus.fu_ready;
      hold_idx <= sel_idx;
    end
  end
endmodule

// File: tb/tb_rs_array.sv
// Scoreboard bench for rs_array: directed scenarios plus randomized traffic,
// checked against an entry-table reference model kept in the bench.
module tb_rs_array;
  localparam int DEPTH = 8;
  localparam int TW    = 5;
  localparam int DW    = 32;
  localparam int AMAX  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_array_if #(.RS_DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) bus ();
  rs_array #(.RS_DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW), .AGE_W(4)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );

  typedef struct { logic [TW-1:0] tag; logic [DW-1:0] rs1; logic [DW-1:0] rs2; } iss_t;
  iss_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: one record per slot.
  bit            m_busy [DEPTH];
  bit            m_r1   [DEPTH];
  bit            m_r2   [DEPTH];
  logic [TW-1:0] m_t1   [DEPTH];
  logic [TW-1:0] m_t2   [DEPTH];
  logic [TW-1:0] m_dest [DEPTH];
  logic [DW-1:0] m_v1   [DEPTH];
  logic [DW-1:0] m_v2   [DEPTH];
  int            m_age  [DEPTH];
  bit            m_hold;
  int            m_hidx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    m_hold = 0;
    m_hidx = 0;
  endtask

  function automatic bit m_ready(input int i);
    return m_busy[i] && m_r1[i] && m_r2[i];
  endfunction

  function automatic int m_select();
    int best = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_ready(i)) begin
`ifdef RS_OLDEST_FIRST_EN
        if (best < 0 || m_age[i] > m_age[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
`ifdef RS_OLDEST_FIRST_EN
    if (best >= 0 && m_hold && m_ready(m_hidx) && m_age[m_hidx] >= m_age[best]) best = m_hidx;
`else
    if (best >= 0 && m_hold && m_ready(m_hidx)) best = m_hidx;
`endif
    return best;
  endfunction

  function automatic bit woke(input logic [TW-1:0] tag);
    return bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == tag;
  endfunction

  task automatic idle();
    bus.squash = 0; bus.disp_valid = 0; bus.cdb_valid = 0;
  endtask

  task automatic disp(input logic [TW-1:0] dst, input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                      input bit r1, input bit r2, input logic [DW-1:0] rf1, input logic [DW-1:0] rf2,
                      input logic [DW-1:0] rob1, input logic [DW-1:0] rob2);
    bus.disp_valid = 1; bus.disp_dest_tag = dst;
    bus.disp_rs1_tag = t1; bus.disp_rs2_tag = t2;
    bus.disp_rs1_ready = r1; bus.disp_rs2_ready = r2;
    bus.disp_rf_rs1 = rf1; bus.disp_rf_rs2 = rf2;
    bus.disp_rob_rs1 = rob1; bus.disp_rob_rs2 = rob2;
  endtask

  task automatic cdb(input logic [TW-1:0] t, input logic [DW-1:0] v);
    bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_value = v;
  endtask

  // One cycle: check status against the model, queue any expected issue, advance the model.
  task automatic step();
    int sel, fidx, nfree;
    #1;
    sel = m_select();
    nfree = 0; fidx = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) begin nfree++; if (fidx < 0) fidx = i; end
    chk("free_count", 64'(bus.free_count), 64'(nfree));
    chk("full", 64'(bus.full), 64'(nfree == 0));
    chk("issue_valid", 64'(bus.issue_valid), 64'(sel >= 0));
    if (sel >= 0) chk("issue_dest_tag", 64'(bus.issue_dest_tag), 64'(m_dest[sel]));
    if (sel >= 0 && bus.fu_ready && !bus.squash) exp_q.push_back('{m_dest[sel], m_v1[sel], m_v2[sel]});
    if (bus.squash) begin
      m_clear();
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i]) begin
          if (m_age[i] < AMAX) m_age[i]++;
          if (!m_r1[i] && woke(m_t1[i])) begin m_r1[i] = 1; m_v1[i] = bus.cdb_value; end
          if (!m_r2[i] && woke(m_t2[i])) begin m_r2[i] = 1; m_v2[i] = bus.cdb_value; end
        end
      end
      m_hold = (sel >= 0) && !bus.fu_ready;
      m_hidx = (sel >= 0) ? sel : 0;
      if (sel >= 0 && bus.fu_ready) m_busy[sel] = 0;
      if (bus.disp_valid && fidx >= 0) begin
        m_busy[fidx] = 1; m_age[fidx] = 0; m_dest[fidx] = bus.disp_dest_tag;
        m_t1[fidx] = bus.disp_rs1_tag; m_t2[fidx] = bus.disp_rs2_tag;
        m_r1[fidx] = 1; m_r2[fidx] = 1;
        if (bus.disp_rs1_tag == 0) m_v1[fidx] = bus.disp_rf_rs1;
        else if (bus.disp_rs1_ready) m_v1[fidx] = bus.disp_rob_rs1;
        else if (woke(bus.disp_rs1_tag)) m_v1[fidx] = bus.cdb_value;
        else m_r1[fidx] = 0;
        if (bus.disp_rs2_tag == 0) m_v2[fidx] = bus.disp_rf_rs2;
        else if (bus.disp_rs2_ready) m_v2[fidx] = bus.disp_rob_rs2;
        else if (woke(bus.disp_rs2_tag)) m_v2[fidx] = bus.cdb_value;
        else m_r2[fidx] = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Pops one expected issue for every fired issue the DUT presents.
  task automatic monitor();
    iss_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.issue_valid && bus.fu_ready && !bus.squash) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL issue_unexpected: got tag %0h expected no issue", bus.issue_dest_tag);
        end else begin
          e = exp_q.pop_front();
          chk("sb_tag", 64'(bus.issue_dest_tag), 64'(e.tag));
          chk("sb_rs1", 64'(bus.issue_rs1), 64'(e.rs1));
          chk("sb_rs2", 64'(bus.issue_rs2), 64'(e.rs2));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fork monitor(); join_none
    idle(); bus.fu_ready = 0;
    bus.disp_dest_tag = 0; bus.disp_rs1_tag = 0; bus.disp_rs2_tag = 0;
    bus.disp_rs1_ready = 0; bus.disp_rs2_ready = 0;
    bus.disp_rf_rs1 = 0; bus.disp_rf_rs2 = 0; bus.disp_rob_rs1 = 0; bus.disp_rob_rs2 = 0;
    bus.cdb_tag = 0; bus.cdb_value = 0;
    m_clear();
    #12;
    chk("rst_free_count", 64'(bus.free_count), 64'd8);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("rst_issue_rs1", 64'(bus.issue_rs1), 64'd0);
    @(posedge clk); #1; rst = 0;

    // Register-file operands: ready on the next cycle.
    disp(1, 0, 0, 0, 0, 1, 1, 0, 0); step(); idle();
    chk("rf_issue_valid", 64'(bus.issue_valid), 64'd1);
    chk("rf_issue_rs1", 64'(bus.issue_rs1), 64'd1);
    chk("rf_issue_rs2", 64'(bus.issue_rs2), 64'd1);
    bus.fu_ready = 1; step(); bus.fu_ready = 0;

    // CDB wakeup of both operands.
    disp(8, 3, 4, 0, 0, 0, 0, 0, 0); step(); idle();
    cdb(4, 10); step(); idle();
    chk("wake_half_valid", 64'(bus.issue_valid), 64'd0);
    cdb(3, 10); step(); idle();
    chk("wake_valid", 64'(bus.issue_valid), 64'd1);
    chk("wake_rs1", 64'(bus.issue_rs1), 64'd10);
    chk("wake_rs2", 64'(bus.issue_rs2), 64'd10);
    bus.fu_ready = 1; step(); bus.fu_ready = 0;

    // Dispatch-cycle CDB bypass.
    disp(12, 2, 0, 0, 0, 0, 5, 0, 0); cdb(2, 7); step(); idle();
    chk("bypass_valid", 64'(bus.issue_valid), 64'd1);
    chk("bypass_rs1", 64'(bus.issue_rs1), 64'd7);
    bus.fu_ready = 1; step(); bus.fu_ready = 0;

    // Fill, overflow dispatch ignored, one issue frees one slot.
    for (int i = 0; i < DEPTH; i++) begin
      disp(TW'(i + 1), 0, 0, 0, 0, $urandom, $urandom, 0, 0); step();
    end
    idle();
    chk("fill_full", 64'(bus.full), 64'd1);
    disp(30, 0, 0, 0, 0, 99, 99, 0, 0); step(); idle();
    chk("ovf_free_count", 64'(bus.free_count), 64'd0);
    bus.fu_ready = 1; step(); bus.fu_ready = 0;
    chk("one_free", 64'(bus.free_count), 64'd1);

    // Squash with 5 busy and concurrent dispatch.
    bus.fu_ready = 1; step(); step(); bus.fu_ready = 0;
    chk("pre_squash_free", 64'(bus.free_count), 64'd3);
    bus.squash = 1; bus.fu_ready = 1; disp(17, 0, 0, 0, 0, 1, 1, 0, 0); step(); idle();
    bus.fu_ready = 0;
    chk("squash_free", 64'(bus.free_count), 64'd8);
    chk("squash_issue_valid", 64'(bus.issue_valid), 64'd0);

    // Age ordering: entry 3 at age 5 and entry 0 at age 1 become ready together.
    disp(20, 0, 0, 0, 0, 2, 2, 0, 0); step();
    disp(21, 9, 0, 0, 0, 0, 0, 0, 0); step();
    disp(22, 9, 0, 0, 0, 0, 0, 0, 0); step();
    disp(23, 3, 0, 0, 0, 0, 4, 0, 0); step(); idle();
    bus.fu_ready = 1; step(); bus.fu_ready = 0;
    step(); step();
    disp(24, 3, 0, 0, 0, 0, 6, 0, 0); step(); idle();
    cdb(3, 11); step(); idle();
`ifdef RS_OLDEST_FIRST_EN
    chk("age_select", 64'(bus.issue_dest_tag), 64'd23);
`else
    chk("age_select", 64'(bus.issue_dest_tag), 64'd24);
`endif
    bus.fu_ready = 1; step(); step(); bus.fu_ready = 0;
    bus.squash = 1; step(); idle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(99) < 60)
        disp(TW'($urandom), TW'($urandom_range(7)), TW'($urandom_range(7)),
             1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(99) < 50) cdb(TW'($urandom_range(7)), $urandom);
      bus.fu_ready = 1'($urandom);
      bus.squash = ($urandom_range(99) < 2);
      step();
    end
    idle();

    // Asynchronous reset in the middle of activity.
    bus.fu_ready = 0;
    disp(5, 0, 0, 0, 0, 3, 3, 0, 0); step();
    disp(6, 0, 0, 0, 0, 4, 4, 0, 0); step(); idle();
    #2 rst = 1;
    #1;
    chk("midrst_free", 64'(bus.free_count), 64'd8);
    chk("midrst_issue_valid", 64'(bus.issue_valid), 64'd0);
    m_clear();
    @(posedge clk); #1; rst = 0;
    disp(7, 0, 0, 0, 0, 8, 9, 0, 0); step(); idle();
    bus.fu_ready = 1; step(); step(); bus.fu_ready = 0;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
